// File: rtl/mem_io_pkg.sv
// Shared types and constants for the LC-3 memory/IO controller.
// Holds the controller state encoding, the default IO address and the address widths.
package mem_io_pkg;

  localparam int ADDR_W      = 16;
  localparam int SRAM_ADDR_W = 20;

  localparam logic [ADDR_W-1:0] IO_ADDR_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ACC,
    S_WR_ACC,
    S_IO_DONE,
    S_DONE
  } state_e;

endpackage

// File: rtl/mem_io_ctrl_wait_ctr.sv
// 4-bit wait-state counter: loads a start value, counts down on request,
// and flags when it has reached zero.
module wait_ctr (
  input  logic       clk,
  input  logic       srst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 4'd0);

endmodule

// File: rtl/mem_io_ctrl.sv
// Memory/IO controller behind the LC-3 control unit: runs fixed-length SRAM
// accesses, serves the switch/hex IO word, and returns a one-cycle Ready.
module mem_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int                WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [ADDR_W-1:0]      ADDR,
  input  logic [15:0]            Data_from_CPU,
  input  logic                   Mem_CE,
  input  logic                   Mem_OE,
  input  logic                   Mem_WE,
  input  logic [15:0]            Switches,
  output logic [15:0]            Data_to_CPU,
  output logic                   Ready,
  output logic [15:0]            HEX_Data,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic [15:0]            SRAM_DOUT,
  output logic                   SRAM_DQ_OE,
  input  logic [15:0]            SRAM_DIN,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [15:0]       hex_q, hex_d;
  logic              ready_q, ready_d;

  logic rd, wr;
  logic ctr_load, ctr_dec, ctr_zero;

  assign rd = ~Mem_CE & ~Mem_OE;
  assign wr = ~Mem_CE & ~Mem_WE;

  wait_ctr u_wait_ctr (
    .clk      (Clk),
    .srst     (Reset),
    .load     (ctr_load),
    .load_val (WAIT_LOAD),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    is_wr_d  = is_wr_q;
    rdata_d  = rdata_q;
    hex_d    = hex_q;
    ready_d  = 1'b0;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rd || wr) begin
          addr_d  = ADDR;
          wdata_d = Data_from_CPU;
          is_wr_d = wr;  // write wins when both strobes are active
          if (ADDR == IO_ADDR) begin
            state_d = S_IO_DONE;
          end else begin
            state_d  = wr ? S_WR_ACC : S_RD_ACC;
            ctr_load = 1'b1;
          end
        end
      end
      S_RD_ACC: begin
        if (!rd) begin
          state_d = S_IDLE;
        end else if (ctr_zero) begin
          rdata_d = SRAM_DIN;
          ready_d = 1'b1;
          state_d = S_DONE;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      S_WR_ACC: begin
        if (!wr) begin
          state_d = S_IDLE;
        end else if (ctr_zero) begin
          ready_d = 1'b1;
          state_d = S_DONE;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      S_IO_DONE: begin
        if (is_wr_q) begin
          hex_d = wdata_q;
        end else begin
          rdata_d = Switches;
        end
        ready_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        // Hold here until the control unit drops its request so one request never runs twice.
        if (!rd && !wr) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
      hex_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
      ready_q <= ready_d;
    end
  end

  logic in_rd, in_wr;
  assign in_rd = (state_q == S_RD_ACC);
  assign in_wr = (state_q == S_WR_ACC);

  assign SRAM_CE_N  = ~(in_rd | in_wr);
  assign SRAM_OE_N  = ~in_rd;
  assign SRAM_WE_N  = ~in_wr;
  assign SRAM_UB_N  = SRAM_CE_N;
  assign SRAM_LB_N  = SRAM_CE_N;
  assign SRAM_DQ_OE = in_wr;
  assign SRAM_DOUT  = wdata_q;
  assign SRAM_ADDR  = {4'b0000, addr_q};

  assign Data_to_CPU = rdata_q;
  assign HEX_Data    = hex_q;
  assign Ready       = ready_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl: drives control-unit strobes on the falling
// edge and checks outputs half a cycle after each rising edge.
module tb_mem_io_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic        Mem_CE, Mem_OE, Mem_WE;
  logic [15:0] Switches;
  logic [15:0] Data_to_CPU;
  logic        Ready;
  logic [15:0] HEX_Data;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DOUT;
  logic        SRAM_DQ_OE;
  logic [15:0] SRAM_DIN;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  int errors = 0;
  int checks = 0;

  mem_io_ctrl #(.WAIT_STATES(2), .IO_ADDR(16'hFFFF)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .ADDR          (ADDR),
    .Data_from_CPU (Data_from_CPU),
    .Mem_CE        (Mem_CE),
    .Mem_OE        (Mem_OE),
    .Mem_WE        (Mem_WE),
    .Switches      (Switches),
    .Data_to_CPU   (Data_to_CPU),
    .Ready         (Ready),
    .HEX_Data      (HEX_Data),
    .SRAM_ADDR     (SRAM_ADDR),
    .SRAM_DOUT     (SRAM_DOUT),
    .SRAM_DQ_OE    (SRAM_DQ_OE),
    .SRAM_DIN      (SRAM_DIN),
    .SRAM_CE_N     (SRAM_CE_N),
    .SRAM_OE_N     (SRAM_OE_N),
    .SRAM_WE_N     (SRAM_WE_N),
    .SRAM_UB_N     (SRAM_UB_N),
    .SRAM_LB_N     (SRAM_LB_N)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle_bus();
    Mem_CE = 1'b1;
    Mem_OE = 1'b1;
    Mem_WE = 1'b1;
  endtask

  int rdy_cnt;
  int oe_cnt;

  initial begin
    Reset = 1'b1;
    ADDR = 16'h0000;
    Data_from_CPU = 16'h0000;
    Switches = 16'h0000;
    SRAM_DIN = 16'h0000;
    idle_bus();
    @(negedge Clk);
    tick();
    tick();

    // Reset state
    check_eq("rst_ready", Ready, 1'b0);
    check_eq("rst_data", Data_to_CPU, 16'h0000);
    check_eq("rst_hex", HEX_Data, 16'h0000);
    check_eq("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'b11111);
    check_eq("rst_dq_oe", SRAM_DQ_OE, 1'b0);
    check_eq("rst_addr", SRAM_ADDR, 20'h00000);
    Reset = 1'b0;
    tick();

    // SRAM read, 2 wait states
    ADDR = 16'h0010; SRAM_DIN = 16'hBEEF;
    Mem_CE = 1'b0; Mem_OE = 1'b0;
    tick();
    check_eq("rd_c1_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'b00100);
    check_eq("rd_c1_addr", SRAM_ADDR, 20'h00010);
    check_eq("rd_c1_ready", Ready, 1'b0);
    ADDR = 16'h0099;
    tick();
    check_eq("rd_c2_oe", SRAM_OE_N, 1'b0);
    check_eq("rd_c2_addr_latched", SRAM_ADDR, 20'h00010);
    check_eq("rd_c2_ready", Ready, 1'b0);
    check_eq("rd_c2_data", Data_to_CPU, 16'h0000);
    tick();
    check_eq("rd_c3_oe", SRAM_OE_N, 1'b1);
    check_eq("rd_c3_ready", Ready, 1'b1);
    check_eq("rd_c3_data", Data_to_CPU, 16'hBEEF);
    idle_bus();
    tick();
    check_eq("rd_c4_ready", Ready, 1'b0);
    check_eq("rd_c4_data_held", Data_to_CPU, 16'hBEEF);

    // SRAM write with OE also low: write must win
    ADDR = 16'h0020; Data_from_CPU = 16'h1234;
    Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = 1'b0;
    tick();
    check_eq("wr_c1_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'b01000);
    check_eq("wr_c1_dq_oe", SRAM_DQ_OE, 1'b1);
    check_eq("wr_c1_dout", SRAM_DOUT, 16'h1234);
    Data_from_CPU = 16'hFFFF;
    tick();
    check_eq("wr_c2_we", SRAM_WE_N, 1'b0);
    check_eq("wr_c2_dout", SRAM_DOUT, 16'h1234);
    check_eq("wr_c2_ready", Ready, 1'b0);
    tick();
    check_eq("wr_c3_we", SRAM_WE_N, 1'b1);
    check_eq("wr_c3_dq_oe", SRAM_DQ_OE, 1'b0);
    check_eq("wr_c3_ready", Ready, 1'b1);
    check_eq("wr_c3_hex", HEX_Data, 16'h0000);
    check_eq("wr_c3_data_kept", Data_to_CPU, 16'hBEEF);
    idle_bus();
    tick();
    check_eq("wr_c4_ready", Ready, 1'b0);

    // IO write to the hex register
    ADDR = 16'hFFFF; Data_from_CPU = 16'h00A5;
    Mem_CE = 1'b0; Mem_WE = 1'b0;
    tick();
    check_eq("iow_c1_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
    check_eq("iow_c1_ready", Ready, 1'b0);
    tick();
    check_eq("iow_c2_ready", Ready, 1'b1);
    check_eq("iow_c2_hex", HEX_Data, 16'h00A5);
    check_eq("iow_c2_ce", SRAM_CE_N, 1'b1);
    idle_bus();
    tick();

    // IO read of the switches
    Switches = 16'h0C3C;
    Mem_CE = 1'b0; Mem_OE = 1'b0;
    tick();
    check_eq("ior_c1_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
    check_eq("ior_c1_ready", Ready, 1'b0);
    tick();
    check_eq("ior_c2_ready", Ready, 1'b1);
    check_eq("ior_c2_data", Data_to_CPU, 16'h0C3C);
    check_eq("ior_c2_hex_kept", HEX_Data, 16'h00A5);
    idle_bus();
    tick();

    // Request held for 6 cycles: one access, one Ready
    ADDR = 16'h0044; SRAM_DIN = 16'h5A5A;
    Mem_CE = 1'b0; Mem_OE = 1'b0;
    rdy_cnt = 0; oe_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      rdy_cnt += int'(Ready);
      oe_cnt  += int'(!SRAM_OE_N);
    end
    idle_bus();
    for (int i = 0; i < 3; i++) begin
      tick();
      rdy_cnt += int'(Ready);
      oe_cnt  += int'(!SRAM_OE_N);
    end
    check_eq("hold_ready_count", rdy_cnt, 1);
    check_eq("hold_oe_cycles", oe_cnt, 2);
    check_eq("hold_data", Data_to_CPU, 16'h5A5A);

    // Abort after one RD_ACC cycle
    ADDR = 16'h0030; SRAM_DIN = 16'h1111;
    Mem_CE = 1'b0; Mem_OE = 1'b0;
    tick();
    check_eq("abt_c1_oe", SRAM_OE_N, 1'b0);
    Mem_OE = 1'b1;
    tick();
    check_eq("abt_c2_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_UB_N}, 3'b111);
    check_eq("abt_c2_ready", Ready, 1'b0);
    rdy_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      rdy_cnt += int'(Ready);
    end
    Mem_CE = 1'b1;
    check_eq("abt_no_ready", rdy_cnt, 0);
    check_eq("abt_data_kept", Data_to_CPU, 16'h5A5A);
    tick();

    // Reset during WR_ACC
    ADDR = 16'h0040; Data_from_CPU = 16'h7777;
    Mem_CE = 1'b0; Mem_WE = 1'b0;
    tick();
    check_eq("rstw_c1_we", SRAM_WE_N, 1'b0);
    Reset = 1'b1;
    tick();
    check_eq("rstw_we", SRAM_WE_N, 1'b1);
    check_eq("rstw_dq_oe", SRAM_DQ_OE, 1'b0);
    check_eq("rstw_hex", HEX_Data, 16'h0000);
    check_eq("rstw_ready", Ready, 1'b0);
    Reset = 1'b0;
    idle_bus();
    tick();
    check_eq("rstw_after_ready", Ready, 1'b0);
    check_eq("rstw_after_ce", SRAM_CE_N, 1'b1);

    // A fresh read after reset runs with normal latency, so the FSM is in IDLE
    ADDR = 16'h0050; SRAM_DIN = 16'hCAFE;
    Mem_CE = 1'b0; Mem_OE = 1'b0;
    tick();
    check_eq("post_c1_oe", SRAM_OE_N, 1'b0);
    tick();
    tick();
    check_eq("post_c3_ready", Ready, 1'b1);
    check_eq("post_c3_data", Data_to_CPU, 16'hCAFE);
    idle_bus();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
